// File: rtl/ram_bus_initiator.sv
// ram_bus_initiator
// Turns single local requests into one RAM bus transaction at a time.
// Each transaction runs SETUP (select asserted, latch low) for one cycle,
// then ACCESS (select and latch high) until the responder acks or the
// wait limit expires, then RESP (one-cycle completion strobe).
//
// Ports
//   clk, nRst           : clock, asynchronous active-low reset
//   ReqValid/ReqReady   : local request handshake (ready only in IDLE)
//   ReqWrnRd            : 1 = write, 0 = read
//   ReqAddress/ReqData  : word address and write data of the request
//   RspValid            : one-cycle completion strobe
//   RspData/RspTimeout  : read data (0 for writes/aborts), abort flag
//   RamBus*             : registered bus outputs, ack and read data inputs
//   TimeoutCount        : saturating count of aborted transactions
module ram_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrnRd,
  input  logic [13:0] ReqAddress,
  input  logic [31:0] ReqData,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic        RspTimeout,
  output logic        RamBusnCs,
  output logic        RamBusWrnRd,
  output logic        RamBusLatch,
  output logic [13:0] RamBusAddress,
  output logic [31:0] RamBusDataOut,
  input  logic [31:0] RamBusDataIn,
  input  logic        RamBusAck,
  output logic [7:0]  TimeoutCount
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Abort fires on the ACCESS edge where the wait counter reaches this value,
  // so exactly TIMEOUT_CYCLES ACCESS cycles elapse before giving up.
  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        cs_q, cs_d;
  logic        latch_q, latch_d;
  logic        wrnrd_q, wrnrd_d;
  logic [13:0] addr_q, addr_d;
  logic [31:0] dout_q, dout_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [7:0]  timeout_count_q, timeout_count_d;
  logic [15:0] access_count_q, access_count_d;

  always_comb begin
    state_d         = state_q;
    cs_d            = cs_q;
    latch_d         = latch_q;
    wrnrd_d         = wrnrd_q;
    addr_d          = addr_q;
    dout_d          = dout_q;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = rsp_data_q;
    rsp_timeout_d   = rsp_timeout_q;
    timeout_count_d = timeout_count_q;
    access_count_d  = access_count_q;

    case (state_q)
      IDLE: begin
        // ReqReady is high throughout IDLE, so ReqValid alone means acceptance.
        if (ReqValid) begin
          wrnrd_d = ReqWrnRd;
          addr_d  = ReqAddress;
          dout_d  = ReqData;
          cs_d    = 1'b1;
          latch_d = 1'b0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        latch_d        = 1'b1;
        access_count_d = 16'd0;
        state_d        = ACCESS;
      end

      ACCESS: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (RamBusAck) begin
          cs_d          = 1'b0;
          latch_d       = 1'b0;
          rsp_data_d    = wrnrd_q ? 32'd0 : RamBusDataIn;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (access_count_q == LAST_COUNT) begin
          cs_d          = 1'b0;
          latch_d       = 1'b0;
          rsp_data_d    = 32'd0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          if (timeout_count_q != 8'hFF) begin
            timeout_count_d = timeout_count_q + 8'd1;
          end
          state_d       = RESP;
        end else begin
          access_count_d = access_count_q + 16'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q         <= IDLE;
      cs_q            <= 1'b0;
      latch_q         <= 1'b0;
      wrnrd_q         <= 1'b0;
      addr_q          <= 14'd0;
      dout_q          <= 32'd0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= 32'd0;
      rsp_timeout_q   <= 1'b0;
      timeout_count_q <= 8'd0;
      access_count_q  <= 16'd0;
    end else begin
      state_q         <= state_d;
      cs_q            <= cs_d;
      latch_q         <= latch_d;
      wrnrd_q         <= wrnrd_d;
      addr_q          <= addr_d;
      dout_q          <= dout_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_timeout_q   <= rsp_timeout_d;
      timeout_count_q <= timeout_count_d;
      access_count_q  <= access_count_d;
    end
  end

  // Ready is decoded straight from the state register so it reads 1 as soon
  // as reset forces IDLE.
  assign ReqReady      = (state_q == IDLE);
  assign RspValid      = rsp_valid_q;
  assign RspData       = rsp_data_q;
  assign RspTimeout    = rsp_timeout_q;
  assign RamBusnCs     = cs_q;
  assign RamBusWrnRd   = wrnrd_q;
  assign RamBusLatch   = latch_q;
  assign RamBusAddress = addr_q;
  assign RamBusDataOut = dout_q;
  assign TimeoutCount  = timeout_count_q;

endmodule

// File: tb/tb_ram_bus_initiator.sv
// tb_ram_bus_initiator
// Self-checking bench for ram_bus_initiator with TIMEOUT_CYCLES = 4.
// Stimulus pushes the expected response into a scoreboard queue; a monitor
// pops and compares it whenever RspValid is seen. Bus phase timing is checked
// cycle by cycle inside the stimulus task.
module tb_ram_bus_initiator;

  localparam int TMO = 4;

  logic        clk;
  logic        nRst;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrnRd;
  logic [13:0] ReqAddress;
  logic [31:0] ReqData;
  logic        RspValid;
  logic [31:0] RspData;
  logic        RspTimeout;
  logic        RamBusnCs;
  logic        RamBusWrnRd;
  logic        RamBusLatch;
  logic [13:0] RamBusAddress;
  logic [31:0] RamBusDataOut;
  logic [31:0] RamBusDataIn;
  logic        RamBusAck;
  logic [7:0]  TimeoutCount;

  typedef struct {
    logic [31:0] data;
    logic        timeout;
    logic [7:0]  tcount;
  } rsp_t;

  rsp_t rspQueue[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   expTimeouts = 0;

  ram_bus_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .nRst          (nRst),
    .ReqValid      (ReqValid),
    .ReqReady      (ReqReady),
    .ReqWrnRd      (ReqWrnRd),
    .ReqAddress    (ReqAddress),
    .ReqData       (ReqData),
    .RspValid      (RspValid),
    .RspData       (RspData),
    .RspTimeout    (RspTimeout),
    .RamBusnCs     (RamBusnCs),
    .RamBusWrnRd   (RamBusWrnRd),
    .RamBusLatch   (RamBusLatch),
    .RamBusAddress (RamBusAddress),
    .RamBusDataOut (RamBusDataOut),
    .RamBusDataIn  (RamBusDataIn),
    .RamBusAck     (RamBusAck),
    .TimeoutCount  (TimeoutCount)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  // Scoreboard monitor: every completion strobe must match the oldest
  // expected response, and no strobe may appear without one pending
  always @(negedge clk) begin
    if (nRst && RspValid) begin
      if (rspQueue.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = rspQueue.pop_front();
        checkOutput("rsp_data", RspData, e.data);
        checkOutput("rsp_timeout", {31'd0, RspTimeout}, {31'd0, e.timeout});
        checkOutput("timeout_count", {24'd0, TimeoutCount}, {24'd0, e.tcount});
      end
    end
  end

  // Runs one full transaction. Called at posedge+1 with the DUT idle.
  // waits = ACCESS cycles without ack before the ack cycle; waits >= TMO
  // means the responder never acks. tieAck holds ack high the whole time.
  task automatic applyStimulus(input logic wr, input logic [13:0] addr,
                               input logic [31:0] wdata, input int waits,
                               input logic tieAck, input logic [31:0] rdata,
                               input logic holdValid);
    rsp_t e;
    int   accessCycles;
    logic isTimeout;
    isTimeout = !tieAck && (waits >= TMO);
    accessCycles = tieAck ? 1 : (isTimeout ? TMO : waits + 1);
    if (isTimeout && expTimeouts < 255) expTimeouts++;
    e.data    = (isTimeout || wr) ? 32'd0 : rdata;
    e.timeout = isTimeout;
    e.tcount  = 8'(expTimeouts);
    rspQueue.push_back(e);

    ReqValid     = 1'b1;
    ReqWrnRd     = wr;
    ReqAddress   = addr;
    ReqData      = wdata;
    RamBusDataIn = rdata;
    RamBusAck    = tieAck;

    @(posedge clk) #1;
    checkOutput("setup_ncs", {31'd0, RamBusnCs}, 32'd1);
    checkOutput("setup_latch", {31'd0, RamBusLatch}, 32'd0);
    checkOutput("setup_ready", {31'd0, ReqReady}, 32'd0);
    checkOutput("setup_addr", {18'd0, RamBusAddress}, {18'd0, addr});
    checkOutput("setup_dout", RamBusDataOut, wdata);
    checkOutput("setup_wrnrd", {31'd0, RamBusWrnRd}, {31'd0, wr});
    if (holdValid) begin
      ReqAddress = ~addr;
      ReqData    = ~wdata;
      ReqWrnRd   = ~wr;
    end else begin
      ReqValid = 1'b0;
    end

    for (int i = 0; i < accessCycles; i++) begin
      @(posedge clk) #1;
      checkOutput("access_ncs", {31'd0, RamBusnCs}, 32'd1);
      checkOutput("access_latch", {31'd0, RamBusLatch}, 32'd1);
      checkOutput("access_rspvalid", {31'd0, RspValid}, 32'd0);
      checkOutput("access_addr", {18'd0, RamBusAddress}, {18'd0, addr});
      checkOutput("access_dout", RamBusDataOut, wdata);
      checkOutput("access_wrnrd", {31'd0, RamBusWrnRd}, {31'd0, wr});
      RamBusAck = tieAck || (i == waits);
    end

    @(posedge clk) #1;
    if (!tieAck) RamBusAck = 1'b0;
    checkOutput("resp_valid", {31'd0, RspValid}, 32'd1);
    checkOutput("resp_ncs", {31'd0, RamBusnCs}, 32'd0);
    checkOutput("resp_latch", {31'd0, RamBusLatch}, 32'd0);
    checkOutput("resp_ready", {31'd0, ReqReady}, 32'd0);
    ReqValid = 1'b0;

    @(posedge clk) #1;
    checkOutput("idle_ready", {31'd0, ReqReady}, 32'd1);
    checkOutput("idle_rspvalid", {31'd0, RspValid}, 32'd0);
    checkOutput("idle_addr_hold", {18'd0, RamBusAddress}, {18'd0, addr});
    checkOutput("idle_dout_hold", RamBusDataOut, wdata);
    checkOutput("idle_rspdata_hold", RspData, e.data);
  endtask

  initial begin
    nRst         = 1'b0;
    ReqValid     = 1'b0;
    ReqWrnRd     = 1'b0;
    ReqAddress   = 14'd0;
    ReqData      = 32'd0;
    RamBusDataIn = 32'd0;
    RamBusAck    = 1'b0;

    #1;
    checkOutput("reset_ready", {31'd0, ReqReady}, 32'd1);
    checkOutput("reset_ncs", {31'd0, RamBusnCs}, 32'd0);
    checkOutput("reset_rspvalid", {31'd0, RspValid}, 32'd0);
    checkOutput("reset_addr", {18'd0, RamBusAddress}, 32'd0);
    checkOutput("reset_tcount", {24'd0, TimeoutCount}, 32'd0);

    @(posedge clk) #1;
    @(posedge clk) #1;
    nRst = 1'b1;

    // Zero-wait write with ack tied high
    applyStimulus(1'b1, 14'h0010, 32'hA5A5_1234, 0, 1'b1, 32'h1111_2222, 1'b0);
    RamBusAck = 1'b0;
    // Read with 3 wait states; ack lands on the timeout edge, ack must win
    applyStimulus(1'b0, 14'h0123, 32'h0, 3, 1'b0, 32'hCAFE_0001, 1'b0);
    // Read with one wait, ReqValid held high throughout the transaction
    applyStimulus(1'b0, 14'h3FFF, 32'h0BAD_F00D, 1, 1'b0, 32'h8765_4321, 1'b1);
    // Write with two waits
    applyStimulus(1'b1, 14'h2A5A, 32'hDEAD_BEEF, 2, 1'b0, 32'h5555_AAAA, 1'b0);
    // Timeout on a read
    applyStimulus(1'b0, 14'h0777, 32'h0, 99, 1'b0, 32'hFFFF_FFFF, 1'b0);

    // Reset pulsed mid-ACCESS abandons the transaction silently
    ReqValid   = 1'b1;
    ReqWrnRd   = 1'b0;
    ReqAddress = 14'h0055;
    RamBusAck  = 1'b0;
    @(posedge clk) #1;
    ReqValid = 1'b0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    checkOutput("pre_rst_latch", {31'd0, RamBusLatch}, 32'd1);
    #2 nRst = 1'b0;
    #1;
    checkOutput("rst_ncs", {31'd0, RamBusnCs}, 32'd0);
    checkOutput("rst_latch", {31'd0, RamBusLatch}, 32'd0);
    checkOutput("rst_ready", {31'd0, ReqReady}, 32'd1);
    checkOutput("rst_tcount", {24'd0, TimeoutCount}, 32'd0);
    expTimeouts = 0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    nRst = 1'b1;
    checkOutput("post_rst_ready", {31'd0, ReqReady}, 32'd1);
    checkOutput("post_rst_rspvalid", {31'd0, RspValid}, 32'd0);

    // Next request after reset completes normally
    applyStimulus(1'b0, 14'h0056, 32'h0, 0, 1'b0, 32'h1234_5678, 1'b0);

    // 300 consecutive timeouts saturate the abort counter
    for (int n = 0; n < 300; n++) begin
      applyStimulus(n[0], 14'(n), 32'(n), 99, 1'b0, 32'(n * 3), 1'b0);
    end
    checkOutput("tcount_saturated", {24'd0, TimeoutCount}, 32'd255);

    // Ack-qualified completion after saturation leaves the counter alone
    applyStimulus(1'b0, 14'h0101, 32'h0, 3, 1'b0, 32'h0F0F_0F0F, 1'b0);
    checkOutput("tcount_still_sat", {24'd0, TimeoutCount}, 32'd255);

    @(posedge clk) #1;
    checkOutput("scoreboard_empty", 32'(rspQueue.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
